// File: rtl/sca_trigger_capture.sv
// Capture-side trigger unit: synchronizes the target trigger, arms on request, applies a
// pre-delay, drives the sampler write enable and records the resulting window length.
module sca_trigger_capture #(
   parameter int CntW       = 16,
   parameter int SyncStages = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            trigger_i,
   input  logic            arm_i,
   input  logic            abort_i,
   input  logic [CntW-1:0] pre_delay_i,
   input  logic [CntW-1:0] max_len_i,
   output logic            armed_o,
   output logic            capture_o,
   output logic            done_o,
   output logic [CntW-1:0] trig_len_o,
   output logic            timeout_o,
   output logic            runt_o
);

   typedef enum logic [2:0] {
      Idle, WaitLow, Armed, Delay, Capture, Done
   } state_e;

   state_e state, state_d;

   logic [SyncStages-1:0] sync;
   logic                  trig_s, trig_d, rise;
   logic [CntW-1:0]       pre_delay, max_len, dly_cnt, len_cnt;

   logic accept, load_dly, start_len, end_len, set_timeout, set_runt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync   <= '0;
         trig_d <= 1'b0;
      end else begin
         sync   <= {sync[SyncStages-2:0], trigger_i};
         trig_d <= trig_s;
      end
   end

   assign trig_s = sync[SyncStages-1];
   assign rise   = trig_s & ~trig_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= Idle;
      else       state <= state_d;
   end

   always_comb begin
      state_d     = state;
      accept      = 1'b0;
      load_dly    = 1'b0;
      start_len   = 1'b0;
      end_len     = 1'b0;
      set_timeout = 1'b0;
      set_runt    = 1'b0;
      case (state)
         Idle: begin
            if (arm_i) begin
               accept  = 1'b1;
               state_d = trig_s ? WaitLow : Armed;
            end
         end
         WaitLow: begin
            if (!trig_s) state_d = Armed;
         end
         Armed: begin
            if (rise) begin
               if (pre_delay == '0) begin
                  start_len = 1'b1;
                  state_d   = Capture;
               end else begin
                  load_dly = 1'b1;
                  state_d  = Delay;
               end
            end
         end
         Delay: begin
            // A trigger that drops before the window opens is a runt, even on the last delay cycle.
            if (!trig_s) begin
               set_runt = 1'b1;
               state_d  = Done;
            end else if (dly_cnt == CntW'(1)) begin
               start_len = 1'b1;
               state_d   = Capture;
            end
         end
         Capture: begin
            if (!trig_s) begin
               end_len = 1'b1;
               state_d = Done;
            end else if (max_len != '0 && len_cnt == max_len) begin
               end_len     = 1'b1;
               set_timeout = 1'b1;
               state_d     = Done;
            end
         end
         Done:    state_d = Idle;
         default: state_d = Idle;
      endcase
      if (abort_i && state != Idle && state != Done) begin
         state_d     = Idle;
         accept      = 1'b0;
         load_dly    = 1'b0;
         start_len   = 1'b0;
         end_len     = 1'b0;
         set_timeout = 1'b0;
         set_runt    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pre_delay  <= '0;
         max_len    <= '0;
         dly_cnt    <= '0;
         len_cnt    <= '0;
         trig_len_o <= '0;
         timeout_o  <= 1'b0;
         runt_o     <= 1'b0;
      end else begin
         if (accept) begin
            pre_delay <= pre_delay_i;
            max_len   <= max_len_i;
            timeout_o <= 1'b0;
            runt_o    <= 1'b0;
         end
         if (load_dly)           dly_cnt <= pre_delay;
         else if (state == Delay) dly_cnt <= dly_cnt - CntW'(1);
         // Unlimited windows saturate rather than wrap so the reported length stays monotonic.
         if (start_len) len_cnt <= CntW'(1);
         else if (state == Capture && len_cnt != '1) len_cnt <= len_cnt + CntW'(1);
         if (set_runt) begin
            runt_o     <= 1'b1;
            trig_len_o <= '0;
         end
         if (end_len) begin
            trig_len_o <= len_cnt;
            timeout_o  <= set_timeout;
         end
      end
   end

   assign armed_o   = (state == WaitLow) || (state == Armed);
   assign capture_o = (state == Capture);
   assign done_o    = (state == Done);

endmodule
